// File: rtl/adc_sample_bcd.sv
// adc_sample_bcd: block-averages 12-bit ADC samples, scales the average to mV and
// converts it to four packed BCD digits with a sequential double-dabble engine. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module adc_sample_bcd #(
  parameter int LOG2_AVG = 3,
  parameter int VREF_MV  = 4096
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  input  logic        clear,
  output logic [11:0] avg_out,
  output logic [13:0] mv_out,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int ACC_W = 12 + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam int SH_W  = 30;
  localparam logic [CNT_W-1:0] BLK_LEN = CNT_W'(2 ** LOG2_AVG);

  typedef enum logic [1:0] {IDLE, SCALE, CONVERT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              overrun_q, overrun_d;
  logic [11:0]       avg_q, avg_d;
  logic [13:0]       mv_q, mv_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [3:0]        iter_q, iter_d;

  logic [ACC_W-1:0]  sum_w;
  logic              blk_done_w;
  logic [11:0]       blk_avg_w;
  logic [13:0]       mv_scaled_w;
  logic [SH_W-1:0]   dabble_adj_w;
  logic [SH_W-1:0]   dabble_w;

  assign sum_w       = acc_q + ACC_W'(sample_in);
  assign blk_done_w  = sample_valid && !clear && (cnt_q + 1'b1 == BLK_LEN);
  assign blk_avg_w   = 12'(sum_w >> LOG2_AVG);
  assign mv_scaled_w = 14'((26'(avg_q) * 26'(VREF_MV)) >> 12);

  // Accumulation is free-running; a block finishing while the converter is busy is lost.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    if (clear) begin
      acc_d     = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else if (sample_valid) begin
      if (blk_done_w) begin
        acc_d     = '0;
        cnt_d     = '0;
        overrun_d = overrun_q | (state_q != IDLE);
      end else begin
        acc_d = sum_w;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // One double-dabble step: bump every BCD nibble >= 5 by 3, then shift left.
  always_comb begin
    dabble_adj_w = sh_q;
    for (int i = 0; i < 4; i++) begin
      if (dabble_adj_w[14 + 4*i +: 4] >= 4'd5) begin
        dabble_adj_w[14 + 4*i +: 4] = dabble_adj_w[14 + 4*i +: 4] + 4'd3;
      end
    end
  end

  assign dabble_w = dabble_adj_w << 1;

  always_comb begin
    state_d = state_q;
    avg_d   = avg_q;
    mv_d    = mv_q;
    bcd_d   = bcd_q;
    sh_d    = sh_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (blk_done_w) begin
          avg_d   = blk_avg_w;
          state_d = SCALE;
        end
      end
      SCALE: begin
        mv_d    = mv_scaled_w;
        sh_d    = {16'b0, mv_scaled_w};
        iter_d  = 4'd0;
        state_d = CONVERT;
      end
      CONVERT: begin
        sh_d   = dabble_w;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd13) begin
          bcd_d   = dabble_w[29:14];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      avg_q     <= '0;
      mv_q      <= '0;
      bcd_q     <= '0;
      sh_q      <= '0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      avg_q     <= avg_d;
      mv_q      <= mv_d;
      bcd_q     <= bcd_d;
      sh_q      <= sh_d;
      iter_q    <= iter_d;
    end
  end

  assign avg_out   = avg_q;
  assign mv_out    = mv_q;
  assign bcd_out   = bcd_q;
  assign bcd_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_sample_bcd.sv
// Bench for adc_sample_bcd: five instances with different averaging/reference settings
// share one stimulus stream and are checked every cycle against an arithmetic model.
`timescale 1ns/1ps
`default_nettype none

module tb_adc_sample_bcd;

  localparam int NDUT = 5;

  function automatic int f_l2(input int i);
    return (i < 2) ? 3 : 0;
  endfunction

  function automatic int f_vref(input int i);
    return (i == 1 || i == 3) ? 5000 : (i == 4) ? 9999 : 4096;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        clear = 1'b0;

  logic [11:0] avg_out   [NDUT];
  logic [13:0] mv_out    [NDUT];
  logic [15:0] bcd_out   [NDUT];
  logic        bcd_valid [NDUT];
  logic        busy      [NDUT];
  logic        overrun   [NDUT];

  always #10 CLOCK_50 = ~CLOCK_50;

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      adc_sample_bcd #(
        .LOG2_AVG((g < 2) ? 3 : 0),
        .VREF_MV ((g == 1 || g == 3) ? 5000 : (g == 4) ? 9999 : 4096)
      ) u_dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .clear       (clear),
        .avg_out     (avg_out[g]),
        .mv_out      (mv_out[g]),
        .bcd_out     (bcd_out[g]),
        .bcd_valid   (bcd_valid[g]),
        .busy        (busy[g]),
        .overrun     (overrun[g])
      );
    end
  endgenerate

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: running sums per instance, conversion start edge and pending results.
  int          cyc = 0;
  int          m_sum   [NDUT];
  int          m_n     [NDUT];
  int          m_start [NDUT];
  int          m_avg   [NDUT];
  int          m_mv    [NDUT];
  int          p_mv    [NDUT];
  logic [15:0] m_bcd   [NDUT];
  logic [15:0] p_bcd   [NDUT];
  bit          m_ovr   [NDUT];

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_sum[i] = 0;  m_n[i] = 0;  m_start[i] = -100;
      m_avg[i] = 0;  m_mv[i] = 0; p_mv[i] = 0;
      m_bcd[i] = '0; p_bcd[i] = '0; m_ovr[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int a;
    cyc++;
    for (int i = 0; i < NDUT; i++) begin
      if (clear) begin
        m_sum[i] = 0; m_n[i] = 0; m_ovr[i] = 1'b0;
      end else if (sample_valid) begin
        m_sum[i] += int'(sample_in);
        m_n[i]++;
        if (m_n[i] == (1 << f_l2(i))) begin
          a = m_sum[i] / (1 << f_l2(i));
          m_sum[i] = 0;
          m_n[i]   = 0;
          if (cyc > m_start[i] + 16) begin
            m_start[i] = cyc;
            m_avg[i]   = a;
            p_mv[i]    = a * f_vref(i) / 4096;
            p_bcd[i]   = to_bcd(p_mv[i]);
          end else begin
            m_ovr[i] = 1'b1;
          end
        end
      end
      if (cyc == m_start[i] + 1)  m_mv[i]  = p_mv[i];
      if (cyc == m_start[i] + 15) m_bcd[i] = p_bcd[i];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLOCK_50 or negedge RESET_N);
      if (!RESET_N) model_reset();
      else          model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge CLOCK_50);
      for (int i = 0; i < NDUT; i++) begin
        chk($sformatf("sb dut%0d {avg,mv,bcd,valid,busy,ovr}", i),
            {avg_out[i], mv_out[i], bcd_out[i], bcd_valid[i], busy[i], overrun[i]},
            {12'(m_avg[i]), 14'(m_mv[i]), m_bcd[i],
             (cyc == m_start[i] + 15),
             (cyc >= m_start[i] && cyc <= m_start[i] + 15),
             m_ovr[i]});
      end
    end
  end

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  function automatic logic any_busy();
    logic b = 1'b0;
    for (int i = 0; i < NDUT; i++) b |= busy[i];
    return b;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (any_busy() && k < 40) begin
      tick();
      k++;
    end
    chk("idle wait", 64'(any_busy()), 64'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic drive_block(input int base, input int step, input int n);
    for (int k = 0; k < n; k++) begin
      sample_in    = 12'(base + k * step);
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  // Latency counts edges including the one that sampled the completing strobe.
  task automatic wait_pulse(input int idx, input int limit, output int lat);
    lat = 1;
    while (!bcd_valid[idx] && lat <= limit) begin
      tick();
      lat++;
    end
  endtask

  typedef struct {
    int idx;
    int base;
    int step;
    int nsamp;
    int exp_avg;
    int exp_mv;
    int exp_bcd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int lat;
    int npulse;
    bit seen;
    logic [15:0] got;

    tbl[0] = '{0, 2048, 0, 8, 2048, 2048, 'h2048};
    tbl[1] = '{0,    0, 1, 8,    3,    3, 'h0003};
    tbl[2] = '{1, 4095, 0, 8, 4095, 4998, 'h4998};
    tbl[3] = '{0, 1000, 0, 8, 1000, 1000, 'h1000};
    tbl[4] = '{1, 1000, 0, 8, 1000, 1220, 'h1220};
    tbl[5] = '{2,  100, 0, 1,  100,  100, 'h0100};
    tbl[6] = '{4, 4095, 0, 1, 4095, 9996, 'h9996};
    tbl[7] = '{3,    1, 0, 1,    1,    1, 'h0001};

    repeat (3) tick();
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("reset state dut%0d", i),
          {avg_out[i], mv_out[i], bcd_out[i], bcd_valid[i], busy[i], overrun[i]}, 64'd0);
    RESET_N = 1'b1;
    tick();

    for (int e = 0; e < 8; e++) begin
      pulse_clear();
      wait_idle();
      drive_block(tbl[e].base, tbl[e].step, tbl[e].nsamp);
      wait_pulse(tbl[e].idx, 40, lat);
      chk($sformatf("vec%0d latency", e), 64'(lat), 64'd16);
      chk($sformatf("vec%0d avg", e), 64'(avg_out[tbl[e].idx]), 64'(tbl[e].exp_avg));
      chk($sformatf("vec%0d mv", e), 64'(mv_out[tbl[e].idx]), 64'(tbl[e].exp_mv));
      chk($sformatf("vec%0d bcd", e), 64'(bcd_out[tbl[e].idx]), 64'(tbl[e].exp_bcd));
    end

    // Back-to-back samples at LOG2_AVG=0: first converts, the rest overrun.
    wait_idle();
    pulse_clear();
    seen = 1'b0;
    got  = '0;
    for (int k = 0; k < 20; k++) begin
      sample_in    = 12'(100 + k);
      sample_valid = 1'b1;
      tick();
      if (bcd_valid[2] && !seen) begin
        seen = 1'b1;
        got  = bcd_out[2];
      end
    end
    sample_valid = 1'b0;
    chk("burst first bcd", 64'(got), 64'h0100);
    chk("burst overrun set", 64'(overrun[2]), 64'd1);
    wait_idle();
    pulse_clear();
    chk("clear drops overrun", 64'(overrun[2]), 64'd0);

    // clear on the 8th strobe discards the whole block.
    wait_idle();
    pulse_clear();
    drive_block(500, 0, 7);
    sample_in    = 12'd500;
    sample_valid = 1'b1;
    clear        = 1'b1;
    tick();
    sample_valid = 1'b0;
    clear        = 1'b0;
    npulse = 0;
    repeat (30) begin
      tick();
      if (bcd_valid[0]) npulse++;
    end
    chk("clear on 8th: no pulse", 64'(npulse), 64'd0);
    drive_block(1000, 0, 8);
    wait_pulse(0, 40, lat);
    chk("after clear bcd", 64'(bcd_out[0]), 64'h1000);

    // Reset in the middle of CONVERT.
    wait_idle();
    pulse_clear();
    drive_block(2048, 0, 8);
    repeat (5) tick();
    #2 RESET_N = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("async reset dut%0d", i),
          {avg_out[i], mv_out[i], bcd_out[i], bcd_valid[i], busy[i], overrun[i]}, 64'd0);
    tick();
    tick();
    RESET_N = 1'b1;
    npulse = 0;
    repeat (30) begin
      tick();
      if (bcd_valid[0]) npulse++;
    end
    chk("aborted block: no pulse", 64'(npulse), 64'd0);
    drive_block(3000, 0, 8);
    wait_pulse(0, 40, lat);
    chk("post-reset latency", 64'(lat), 64'd16);
    chk("post-reset bcd", 64'(bcd_out[0]), 64'h3000);

    // Random traffic; the per-cycle model comparison does the checking.
    wait_idle();
    for (int k = 0; k < 3000; k++) begin
      sample_in    = 12'($urandom_range(0, 4095));
      sample_valid = ($urandom_range(0, 2) == 0);
      clear        = ($urandom_range(0, 63) == 0);
      tick();
    end
    sample_valid = 1'b0;
    clear        = 1'b0;

    // Full code sweep on the single-sample instances.
    wait_idle();
    for (int code = 0; code < 4096; code++) begin
      sample_in    = 12'(code);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      wait_pulse(4, 20, lat);
      for (int i = 2; i < NDUT; i++)
        chk($sformatf("sweep dut%0d code %0d", i, code),
            64'(bcd_out[i]), 64'(to_bcd(code * f_vref(i) / 4096)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
